// File: rtl/cw_target_bridge.sv
// Target-side endpoint of the compressed CW bus. It decodes the header, address
// and data words from the CW link and replays them as classic Wishbone single/burst cycles.
module cw_target_bridge #(
  parameter int WB_ADDR_W = 24,
  parameter int RW        = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [RW-1:0]        cw_io_i,
  output logic [RW-1:0]        cw_io_o,
  output logic                 cw_io_oe,
  input  logic                 cw_req,
  output logic                 cw_ack,
  output logic                 cw_err,
  output logic                 wb_cyc,
  output logic                 wb_stb,
  output logic                 wb_we,
  output logic [WB_ADDR_W-1:0] wb_adr,
  output logic [RW-1:0]        wb_o_dat,
  input  logic [RW-1:0]        wb_i_dat,
  output logic [1:0]           wb_sel,
  input  logic                 wb_ack,
  input  logic                 wb_err
);

  localparam int WDOG_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WREQ,
    S_RREQ,
    S_RRESP,
    S_ERR
  } state_t;

  state_t               r_state;
  logic                 r_we_hdr;
  logic [1:0]           r_burst;
  logic [7:0]           r_adr_hi;
  logic [3:0]           r_beats;
  logic [WDOG_W-1:0]    r_wdog;

  logic [RW-1:0]        r_cw_io_o;
  logic                 r_cw_io_oe;
  logic                 r_cw_ack;
  logic                 r_cw_err;
  logic                 r_wb_cyc;
  logic                 r_wb_stb;
  logic                 r_wb_we;
  logic [WB_ADDR_W-1:0] r_wb_adr;
  logic [RW-1:0]        r_wb_o_dat;
  logic [1:0]           r_wb_sel;

  logic                 w_wdog_exp;
  logic                 w_fail;
  logic                 w_last;
  logic [3:0]           w_hdr_beats;
  logic [WB_ADDR_W-1:0] w_hdr_adr;

  assign w_wdog_exp = (r_wdog == WDOG_W'(TIMEOUT));
  // A slave error beats a simultaneous ack; the watchdog only fires when no response arrives.
  assign w_fail     = wb_err | (~wb_ack & w_wdog_exp);
  assign w_last     = (r_beats == 4'd1);
  assign w_hdr_adr  = WB_ADDR_W'({r_adr_hi, cw_io_i[15:0]});

  always_comb begin
    case (r_burst)
      2'b00:   w_hdr_beats = 4'd1;
      2'b01:   w_hdr_beats = 4'd4;
      2'b10:   w_hdr_beats = 4'd8;
      default: w_hdr_beats = 4'd0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_we_hdr   <= 1'b0;
      r_burst    <= 2'b00;
      r_adr_hi   <= '0;
      r_beats    <= '0;
      r_wdog     <= '0;
      r_cw_io_o  <= '0;
      r_cw_io_oe <= 1'b0;
      r_cw_ack   <= 1'b0;
      r_cw_err   <= 1'b0;
      r_wb_cyc   <= 1'b0;
      r_wb_stb   <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_adr   <= '0;
      r_wb_o_dat <= '0;
      r_wb_sel   <= 2'b00;
    end else begin
      // NOTE: non-blocking defaults at the top turn cw_ack/cw_err into one-cycle pulses;
      // any later assignment in the same cycle overrides them.
      r_cw_ack <= 1'b0;
      r_cw_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (cw_req) begin
            r_we_hdr <= cw_io_i[15];
            r_burst  <= cw_io_i[14:13];
            r_wb_sel <= cw_io_i[12:11];
            r_adr_hi <= cw_io_i[7:0];
            r_state  <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (cw_req) begin
            r_wb_adr <= w_hdr_adr;
            r_beats  <= w_hdr_beats;
            r_wdog   <= '0;
            if (r_burst == 2'b11) begin
              r_cw_err <= 1'b1;
              r_state  <= S_ERR;
            end else if (r_we_hdr) begin
              r_state <= S_WDATA;
            end else begin
              // The bridge takes the bus from the first read request; the address
              // word cycle has already passed, which gives the turnaround gap.
              r_wb_cyc   <= 1'b1;
              r_wb_stb   <= 1'b1;
              r_wb_we    <= 1'b0;
              r_cw_io_oe <= 1'b1;
              r_state    <= S_RREQ;
            end
          end
        end

        S_WDATA: begin
          if (cw_req) begin
            r_wb_o_dat <= cw_io_i;
            r_wb_cyc   <= 1'b1;
            r_wb_stb   <= 1'b1;
            r_wb_we    <= 1'b1;
            r_wdog     <= '0;
            r_state    <= S_WREQ;
          end
        end

        S_WREQ: begin
          if (w_fail) begin
            r_wb_cyc <= 1'b0;
            r_wb_stb <= 1'b0;
            r_wb_we  <= 1'b0;
            r_cw_err <= 1'b1;
            r_state  <= S_ERR;
          end else if (wb_ack) begin
            r_wb_cyc <= 1'b0;
            r_wb_stb <= 1'b0;
            r_wb_we  <= 1'b0;
            r_wb_adr <= r_wb_adr + 1'b1;
            r_beats  <= r_beats - 4'd1;
            r_cw_ack <= 1'b1;
            r_state  <= w_last ? S_IDLE : S_WDATA;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end

        S_RREQ: begin
          if (w_fail) begin
            r_wb_cyc   <= 1'b0;
            r_wb_stb   <= 1'b0;
            r_cw_io_oe <= 1'b0;
            r_cw_err   <= 1'b1;
            r_state    <= S_ERR;
          end else if (wb_ack) begin
            r_wb_cyc  <= 1'b0;
            r_wb_stb  <= 1'b0;
            r_wb_adr  <= r_wb_adr + 1'b1;
            r_cw_io_o <= wb_i_dat;
            r_cw_ack  <= 1'b1;
            r_state   <= S_RRESP;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end

        S_RRESP: begin
          if (w_last) begin
            r_beats    <= '0;
            r_cw_io_oe <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_beats  <= r_beats - 4'd1;
            r_wb_cyc <= 1'b1;
            r_wb_stb <= 1'b1;
            r_wdog   <= '0;
            r_state  <= S_RREQ;
          end
        end

        S_ERR: begin
          r_beats <= '0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cw_io_o  = r_cw_io_o;
  assign cw_io_oe = r_cw_io_oe;
  assign cw_ack   = r_cw_ack;
  assign cw_err   = r_cw_err;
  assign wb_cyc   = r_wb_cyc;
  assign wb_stb   = r_wb_stb;
  assign wb_we    = r_wb_we;
  assign wb_adr   = r_wb_adr;
  assign wb_o_dat = r_wb_o_dat;
  assign wb_sel   = r_wb_sel;

endmodule

// File: tb/tb_cw_target_bridge.sv
// Self-checking bench for cw_target_bridge: drives the CW link as the initiator, models a
// Wishbone slave, and compares the Wishbone cycles and CW responses against spec-derived expectations.
module tb_cw_target_bridge;

  localparam int AW    = 24;
  localparam int TMO   = 20;
  localparam int BOUND = 4 * TMO + 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [15:0]   cw_io_i = '0;
  logic [15:0]   cw_io_o;
  logic          cw_io_oe;
  logic          cw_req = 1'b0;
  logic          cw_ack;
  logic          cw_err;
  logic          wb_cyc;
  logic          wb_stb;
  logic          wb_we;
  logic [AW-1:0] wb_adr;
  logic [15:0]   wb_o_dat;
  logic [15:0]   wb_i_dat = '0;
  logic [1:0]    wb_sel;
  logic          wb_ack = 1'b0;
  logic          wb_err = 1'b0;

  cw_target_bridge #(.WB_ADDR_W(AW), .RW(16), .TIMEOUT(TMO)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .cw_io_i  (cw_io_i),
    .cw_io_o  (cw_io_o),
    .cw_io_oe (cw_io_oe),
    .cw_req   (cw_req),
    .cw_ack   (cw_ack),
    .cw_err   (cw_err),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_we    (wb_we),
    .wb_adr   (wb_adr),
    .wb_o_dat (wb_o_dat),
    .wb_i_dat (wb_i_dat),
    .wb_sel   (wb_sel),
    .wb_ack   (wb_ack),
    .wb_err   (wb_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Event log of the CW side and the bus, sampled mid-cycle.
  int          n_ack = 0, n_err = 0, n_stb = 0, n_oe_bad = 0, n_oe_cyc = 0;
  int          err_cyc = 0, stb_cyc = 0, ack_cyc = 0;
  logic        prev_stb = 1'b0;
  logic [15:0] ack_dat [0:1023];

  always @(negedge clk) begin
    prev_stb <= wb_stb;
    if (wb_stb && !prev_stb) begin
      n_stb   <= n_stb + 1;
      stb_cyc <= cyc_n;
    end
    if (cw_ack) begin
      ack_dat[n_ack % 1024] <= cw_io_o;
      n_ack   <= n_ack + 1;
      ack_cyc <= cyc_n;
    end
    if (cw_err) begin
      n_err   <= n_err + 1;
      err_cyc <= cyc_n;
    end
    if (cw_io_oe) n_oe_cyc <= n_oe_cyc + 1;
    if (cw_io_oe && (cw_req || wb_we)) n_oe_bad <= n_oe_bad + 1;
  end

  // Wishbone slave model: configurable wait states, error injection, silence.
  int          slv_wait   = 0;
  bit          slv_silent = 1'b0;
  bit          slv_both   = 1'b0;
  int          slv_err_at = -1;
  int          slv_rbase  = 0;
  logic [15:0] slv_rdata [0:7];
  int          log_n = 0;
  logic [AW-1:0] log_adr [0:1023];
  logic          log_we  [0:1023];
  logic [1:0]    log_sel [0:1023];
  logic [15:0]   log_dat [0:1023];

  initial begin : slave
    int cnt;
    int k;
    cnt = 0;
    forever begin
      @(negedge clk);
      wb_ack   = 1'b0;
      wb_err   = 1'b0;
      wb_i_dat = 16'($urandom);
      if (wb_cyc && wb_stb && !slv_silent) begin
        if (cnt >= slv_wait) begin
          cnt = 0;
          k   = log_n - slv_rbase;
          if (k == slv_err_at) begin
            wb_err = 1'b1;
          end else if (slv_both) begin
            wb_err = 1'b1;
            wb_ack = 1'b1;
          end else begin
            wb_ack   = 1'b1;
            wb_i_dat = slv_rdata[k % 8];
            log_adr[log_n % 1024] = wb_adr;
            log_we [log_n % 1024] = wb_we;
            log_sel[log_n % 1024] = wb_sel;
            log_dat[log_n % 1024] = wb_we ? wb_o_dat : wb_i_dat;
            log_n++;
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  logic [15:0] wr_dat [0:7];

  function automatic int nbeats(input logic [1:0] burst);
    case (burst)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 0;
    endcase
  endfunction

  task automatic slave_cfg(input int wait_st);
    slv_wait   = wait_st;
    slv_silent = 1'b0;
    slv_both   = 1'b0;
    slv_err_at = -1;
    slv_rbase  = log_n;
  endtask

  task automatic put_word(input logic [15:0] w, input int gap);
    repeat (gap) begin
      @(negedge clk);
      cw_req  = 1'b0;
      cw_io_i = 16'($urandom);
    end
    @(negedge clk);
    cw_req  = 1'b1;
    cw_io_i = w;
  endtask

  task automatic wait_resp(output bit err_seen);
    bit got;
    got = 1'b0;
    err_seen = 1'b0;
    for (int k = 0; k < BOUND && !got; k++) begin
      if (cw_ack || cw_err) begin
        got = 1'b1;
        err_seen = cw_err;
      end else begin
        @(negedge clk);
      end
    end
    total++;
    if (got !== 1'b1) begin
      bad++;
      $display("FAIL resp_wait: no cw_ack/cw_err after %0d cycles (got=%0b, required 1)", BOUND, got);
    end
  endtask

  task automatic run_xfer(input logic we, input logic [1:0] burst, input logic [1:0] sel,
                          input logic [AW-1:0] adr, input int maxgap);
    int n;
    bit done;
    n = nbeats(burst);
    done = 1'b0;
    put_word({we, burst, sel, 3'b000, adr[23:16]}, $urandom_range(maxgap, 0));
    put_word(adr[15:0], $urandom_range(maxgap, 0));
    if (n == 0) begin
      @(negedge clk);
      cw_req = 1'b0;
      wait_resp(done);
    end
    for (int b = 0; b < n && !done; b++) begin
      if (we) put_word(wr_dat[b], $urandom_range(maxgap, 0));
      @(negedge clk);
      cw_req  = 1'b0;
      cw_io_i = 16'($urandom);
      wait_resp(done);
    end
  endtask

  task automatic test_reset();
    logic [63:0] obs;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    obs = {cw_io_o, cw_io_oe, cw_ack, cw_err, wb_cyc, wb_stb, wb_we, wb_adr, wb_o_dat, wb_sel};
    total++;
    if (obs !== 64'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h required 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({wb_cyc, cw_io_oe, cw_ack, cw_err} !== 4'b0000) begin
      bad++;
      $display("FAIL idle_after_reset: got %b required 0000", {wb_cyc, cw_io_oe, cw_ack, cw_err});
    end
  endtask

  task automatic test_single_write();
    int l0, a0, t0, t1;
    bit got;
    slave_cfg(0);
    l0 = log_n;
    a0 = n_ack;
    put_word(16'h9812, 0);
    put_word(16'h3456, 1);
    put_word(16'hBEEF, 0);
    t0 = cyc_n;
    @(negedge clk);
    cw_req = 1'b0;
    got = 1'b0;
    t1 = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (cw_ack) begin
        got = 1'b1;
        t1 = cyc_n;
      end else begin
        @(negedge clk);
      end
    end
    total++;
    if (t1 - t0 !== 2) begin
      bad++;
      $display("FAIL write_latency: got %0d cycles required 2", t1 - t0);
    end
    repeat (3) @(negedge clk);
    total++;
    if (log_n - l0 !== 1) begin
      bad++;
      $display("FAIL single_write_count: got %0d required 1", log_n - l0);
    end
    total++;
    if ({log_adr[l0 % 1024], log_we[l0 % 1024], log_sel[l0 % 1024], log_dat[l0 % 1024]}
        !== {24'h123456, 1'b1, 2'b11, 16'hBEEF}) begin
      bad++;
      $display("FAIL single_write_cycle: got adr=%h we=%b sel=%b dat=%h required 123456/1/11/beef",
               log_adr[l0 % 1024], log_we[l0 % 1024], log_sel[l0 % 1024], log_dat[l0 % 1024]);
    end
    total++;
    if (n_ack - a0 !== 1 || wb_cyc !== 1'b0) begin
      bad++;
      $display("FAIL single_write_ack: got acks=%0d cyc=%b required 1/0", n_ack - a0, wb_cyc);
    end
  endtask

  task automatic test_zero_wait_read();
    int a0;
    slave_cfg(0);
    slv_rdata[0] = 16'h5EED;
    a0 = n_ack;
    run_xfer(1'b0, 2'b00, 2'b10, 24'h3C0001, 0);
    repeat (2) @(negedge clk);
    total++;
    if (ack_cyc - stb_cyc !== 1) begin
      bad++;
      $display("FAIL read_latency: got %0d cycles required 1", ack_cyc - stb_cyc);
    end
    total++;
    if (ack_dat[a0 % 1024] !== 16'h5EED) begin
      bad++;
      $display("FAIL zero_wait_read_data: got %h required 5eed", ack_dat[a0 % 1024]);
    end
  endtask

  task automatic test_read4_wrap();
    int l0, a0, o0, c0;
    logic [AW-1:0] ea;
    slave_cfg(2);
    for (int i = 0; i < 4; i++) slv_rdata[i] = 16'(i + 1);
    l0 = log_n; a0 = n_ack; o0 = n_oe_bad; c0 = n_oe_cyc;
    run_xfer(1'b0, 2'b01, 2'b01, 24'h00FFFE, 1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ea = 24'((32'h00FFFE + i) % 32'h1000000);
      total++;
      if ({log_adr[(l0 + i) % 1024], log_we[(l0 + i) % 1024]} !== {ea, 1'b0}) begin
        bad++;
        $display("FAIL read4_adr[%0d]: got %h we=%b required %h we=0", i,
                 log_adr[(l0 + i) % 1024], log_we[(l0 + i) % 1024], ea);
      end
      total++;
      if (ack_dat[(a0 + i) % 1024] !== 16'(i + 1)) begin
        bad++;
        $display("FAIL read4_data[%0d]: got %h required %h", i, ack_dat[(a0 + i) % 1024], i + 1);
      end
    end
    total++;
    if (n_oe_cyc - c0 !== 4 * (2 + 2) || n_oe_bad - o0 !== 0 || cw_io_oe !== 1'b0) begin
      bad++;
      $display("FAIL read4_oe: got oe_cycles=%0d conflicts=%0d oe_now=%b required 16/0/0",
               n_oe_cyc - c0, n_oe_bad - o0, cw_io_oe);
    end
  endtask

  task automatic test_write8_wrap();
    int l0, a0;
    logic [AW-1:0] ea;
    slave_cfg($urandom_range(3, 0));
    for (int i = 0; i < 8; i++) wr_dat[i] = 16'($urandom);
    l0 = log_n; a0 = n_ack;
    run_xfer(1'b1, 2'b10, 2'b10, 24'hFFFFFC, 3);
    repeat (2) @(negedge clk);
    total++;
    if (n_ack - a0 !== 8 || log_n - l0 !== 8) begin
      bad++;
      $display("FAIL write8_count: got acks=%0d cycles=%0d required 8/8", n_ack - a0, log_n - l0);
    end
    for (int i = 0; i < 8; i++) begin
      ea = 24'((32'hFFFFFC + i) % 32'h1000000);
      total++;
      if ({log_adr[(l0 + i) % 1024], log_sel[(l0 + i) % 1024], log_dat[(l0 + i) % 1024]}
          !== {ea, 2'b10, wr_dat[i]}) begin
        bad++;
        $display("FAIL write8_beat[%0d]: got adr=%h sel=%b dat=%h required %h/10/%h", i,
                 log_adr[(l0 + i) % 1024], log_sel[(l0 + i) % 1024], log_dat[(l0 + i) % 1024],
                 ea, wr_dat[i]);
      end
    end
  endtask

  task automatic test_read_err();
    int a0, e0, s0;
    slave_cfg(1);
    slv_err_at = 1;
    a0 = n_ack; e0 = n_err; s0 = n_stb;
    run_xfer(1'b0, 2'b01, 2'b11, 24'h001000, 0);
    repeat (10) @(negedge clk);
    total++;
    if ({n_ack - a0, n_err - e0, n_stb - s0} !== {32'd1, 32'd1, 32'd2}) begin
      bad++;
      $display("FAIL read_err: got acks=%0d errs=%0d stb=%0d required 1/1/2",
               n_ack - a0, n_err - e0, n_stb - s0);
    end
    total++;
    if ({wb_cyc, cw_io_oe} !== 2'b00) begin
      bad++;
      $display("FAIL read_err_idle: got cyc=%b oe=%b required 0/0", wb_cyc, cw_io_oe);
    end
  endtask

  task automatic test_timeout();
    int a0, e0;
    slave_cfg(0);
    slv_silent = 1'b1;
    wr_dat[0] = 16'h1234;
    a0 = n_ack; e0 = n_err;
    run_xfer(1'b1, 2'b00, 2'b01, 24'h000100, 0);
    repeat (3) @(negedge clk);
    total++;
    if (err_cyc - stb_cyc !== TMO + 1) begin
      bad++;
      $display("FAIL timeout_latency: got %0d cycles required %0d", err_cyc - stb_cyc, TMO + 1);
    end
    total++;
    if ({n_ack - a0, n_err - e0} !== {32'd0, 32'd1} || wb_stb !== 1'b0) begin
      bad++;
      $display("FAIL timeout_resp: got acks=%0d errs=%0d stb=%b required 0/1/0",
               n_ack - a0, n_err - e0, wb_stb);
    end
    slv_silent = 1'b0;
  endtask

  task automatic test_illegal_burst();
    int a0, e0, s0, l0;
    slave_cfg(0);
    a0 = n_ack; e0 = n_err; s0 = n_stb; l0 = log_n;
    run_xfer(1'($urandom), 2'b11, 2'b11, 24'h777777, 1);
    repeat (4) @(negedge clk);
    total++;
    if ({n_err - e0, n_ack - a0, n_stb - s0, log_n - l0} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
      bad++;
      $display("FAIL illegal_burst: got errs=%0d acks=%0d stb=%0d cycles=%0d required 1/0/0/0",
               n_err - e0, n_ack - a0, n_stb - s0, log_n - l0);
    end
  endtask

  task automatic test_ack_err_same();
    int a0, e0;
    slave_cfg(1);
    slv_both = 1'b1;
    a0 = n_ack; e0 = n_err;
    run_xfer(1'b0, 2'b01, 2'b00, 24'h0000A0, 0);
    repeat (4) @(negedge clk);
    total++;
    if ({n_err - e0, n_ack - a0} !== {32'd1, 32'd0}) begin
      bad++;
      $display("FAIL ack_err_same: got errs=%0d acks=%0d required 1/0", n_err - e0, n_ack - a0);
    end
    slv_both = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] obs;
    bit got;
    int l0;
    slave_cfg(6);
    put_word({1'b0, 2'b01, 2'b10, 3'b000, 8'h40}, 0);
    put_word(16'h0010, 0);
    @(negedge clk);
    cw_req = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (wb_stb) got = 1'b1;
      else @(negedge clk);
    end
    total++;
    if ({got, cw_io_oe} !== 2'b11) begin
      bad++;
      $display("FAIL rreq_reached: got stb_seen=%b oe=%b required 1/1", got, cw_io_oe);
    end
    #2 rst_n = 1'b0;
    #1;
    obs = {cw_io_o, cw_io_oe, cw_ack, cw_err, wb_cyc, wb_stb, wb_we, wb_adr, wb_o_dat, wb_sel};
    total++;
    if (obs !== 64'd0) begin
      bad++;
      $display("FAIL async_reset: got %h required 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    slave_cfg(0);
    l0 = log_n;
    wr_dat[0] = 16'hA55A;
    run_xfer(1'b1, 2'b00, 2'b01, 24'h0ABCDE, 1);
    repeat (2) @(negedge clk);
    total++;
    if (log_n - l0 !== 1 ||
        {log_adr[l0 % 1024], log_we[l0 % 1024], log_sel[l0 % 1024], log_dat[l0 % 1024]}
        !== {24'h0ABCDE, 1'b1, 2'b01, 16'hA55A}) begin
      bad++;
      $display("FAIL after_reset_write: got n=%0d adr=%h dat=%h required 1/0abcde/a55a",
               log_n - l0, log_adr[l0 % 1024], log_dat[l0 % 1024]);
    end
  endtask

  task automatic test_random();
    int l0, a0, e0, o0, n;
    logic we;
    logic [1:0] burst, sel;
    logic [AW-1:0] adr, ea;
    logic [15:0] obs_d, exp_d;
    for (int t = 0; t < 25; t++) begin
      we    = 1'($urandom);
      burst = 2'($urandom_range(2, 0));
      sel   = 2'($urandom);
      adr   = (t % 4 == 0) ? 24'hFFFFF8 + 24'($urandom_range(7, 0)) : 24'($urandom);
      for (int i = 0; i < 8; i++) begin
        wr_dat[i]    = 16'($urandom);
        slv_rdata[i] = 16'($urandom);
      end
      slave_cfg($urandom_range(3, 0));
      l0 = log_n; a0 = n_ack; e0 = n_err; o0 = n_oe_bad;
      n = nbeats(burst);
      run_xfer(we, burst, sel, adr, 2);
      repeat (2) @(negedge clk);
      total++;
      if ({log_n - l0, n_ack - a0, n_err - e0, n_oe_bad - o0} !== {n, n, 32'd0, 32'd0}) begin
        bad++;
        $display("FAIL rand%0d_counts: got cycles=%0d acks=%0d errs=%0d oe_conflicts=%0d required %0d/%0d/0/0",
                 t, log_n - l0, n_ack - a0, n_err - e0, n_oe_bad - o0, n, n);
      end
      for (int i = 0; i < n; i++) begin
        ea    = 24'((32'(adr) + i) % 32'h1000000);
        exp_d = we ? wr_dat[i] : slv_rdata[i];
        obs_d = we ? log_dat[(l0 + i) % 1024] : ack_dat[(a0 + i) % 1024];
        total++;
        if ({log_adr[(l0 + i) % 1024], log_we[(l0 + i) % 1024], log_sel[(l0 + i) % 1024], obs_d}
            !== {ea, we, sel, exp_d}) begin
          bad++;
          $display("FAIL rand%0d_beat%0d: got adr=%h we=%b sel=%b dat=%h required %h/%b/%b/%h", t, i,
                   log_adr[(l0 + i) % 1024], log_we[(l0 + i) % 1024], log_sel[(l0 + i) % 1024], obs_d,
                   ea, we, sel, exp_d);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_zero_wait_read();
    test_read4_wrap();
    test_write8_wrap();
    test_read_err();
    test_timeout();
    test_illegal_burst();
    test_ack_err_same();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, bad=%0d", bad);
    $fatal(1, "simulation time limit reached");
  end

endmodule
